regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32x64 register bank between NUM_REQ writeback sources: ALU result, load data, branch-with-link return address. Selects one requester per cycle by round-robin using a valid/ready handshake and registers the winning write into the bank's write/input3/input_data inputs. It also exposes that registered write as a bypass for same-cycle readers, because the bank commits on the next posedge.

---
 rtl/regfile_write_arbiter_pkg.sv | 19 +
 rtl/regfile_write_arbiter_rr_pick.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and helpers for the register-bank write-port arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned ZR_INDEX = 31;

  typedef enum logic [2:0] {
    REQ_ALU  = 3'd0,
    REQ_LOAD = 3'd1,
    REQ_LINK = 3'd2
  } req_id_e;

  // A requester that waits this many unserved cycles is flagged as starved.
  function automatic int unsigned starve_lim(input int unsigned num_req);
    return 2 * num_req;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_ptr, modulo N.
module regfile_write_arbiter_rr_pick #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_valid,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_winner,
  output logic             o_any
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_sum >= (PTR_W+1)'(N)) begin
        w_sum = w_sum - (PTR_W+1)'(N);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && i_valid[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_winner       = w_idx;
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port among writeback sources,
// with a one-cycle registered write stage that doubles as a same-cycle bypass.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = regfile_write_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W  = regfile_write_arbiter_pkg::ADDR_W,
  parameter bit          DROP_ZR = 1'b1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        rf_write,
  output logic [ADDR_W-1:0]           rf_addr,
  output logic [DATA_W-1:0]           rf_data,
  output logic                        fwd_valid,
  output logic [2:0]                  grant_id,
  output logic [NUM_REQ-1:0]          starve
);

  localparam int unsigned PTR_W      = $clog2(NUM_REQ);
  localparam int unsigned STARVE_LIM = starve_lim(NUM_REQ);
  localparam int unsigned CNT_W      = $clog2(STARVE_LIM) + 1;

  logic [PTR_W-1:0]  r_rr_ptr;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_grant_id;
  logic [NUM_REQ-1:0] r_starve;
  logic [CNT_W-1:0]  r_wait [NUM_REQ];

  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_winner;
  logic               w_any;
  logic               w_accept;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_sel_zr;

  regfile_write_arbiter_rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_valid  (req_valid),
    .i_ptr    (r_rr_ptr),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    req_ready  = (stall || reset) ? '0 : w_grant;
    w_accept   = w_any && !stall && !reset;
    w_next_ptr = (w_winner == PTR_W'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    w_sel_addr = req_addr[w_winner*ADDR_W +: ADDR_W];
    w_sel_data = req_data[w_winner*DATA_W +: DATA_W];
    w_sel_zr   = DROP_ZR && (w_sel_addr == ADDR_W'(ZR_INDEX));
  end

  // Address/data/id hold on idle cycles so the bypass keeps showing the last write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_grant_id <= '0;
    end else if (w_accept) begin
      r_rr_ptr   <= w_next_ptr;
      r_write    <= !w_sel_zr;
      r_addr     <= w_sel_addr;
      r_data     <= w_sel_data;
      r_grant_id <= 3'(w_winner);
    end else begin
      r_write    <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        r_wait[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || req_ready[i]) begin
          r_wait[i] <= '0;
        end else if (!stall && (r_wait[i] != CNT_W'(STARVE_LIM))) begin
          r_wait[i] <= r_wait[i] + 1'b1;
        end
        if (r_wait[i] == CNT_W'(STARVE_LIM)) begin
          r_starve[i] <= 1'b1;
        end
      end
    end
  end

  assign rf_write  = r_write;
  assign rf_addr   = r_addr;
  assign rf_data   = r_data;
  assign fwd_valid = r_write;
  assign grant_id  = r_grant_id;
  assign starve    = r_starve;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a scoreboard of expected write-stage contents.
module tb_regfile_write_arbiter;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [63:0] d;
    logic [2:0]  id;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall;
  logic [2:0]    req_valid;
  logic [14:0]   req_addr;
  logic [191:0]  req_data;
  logic [2:0]    req_ready;
  logic          rf_write;
  logic [4:0]    rf_addr;
  logic [63:0]   rf_data;
  logic          fwd_valid;
  logic [2:0]    grant_id;
  logic [2:0]    starve;

  logic          bank_clr;
  logic [63:0]   bank [32];

  int unsigned   n_cmp  = 0;
  int unsigned   n_fail = 0;
  int unsigned   m_ptr  = 0;
  exp_t          m_last;
  exp_t          sb [$];
  int unsigned   acc_obs [3];

  regfile_write_arbiter #(
    .NUM_REQ (3),
    .DATA_W  (64),
    .ADDR_W  (5),
    .DROP_ZR (1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .stall     (stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_write  (rf_write),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .fwd_valid (fwd_valid),
    .grant_id  (grant_id),
    .starve    (starve)
  );

  always #5 clock = ~clock;

  // Behavioural stand-in for the 32x64 bank: commits the registered write on the next edge.
  always @(posedge clock) begin
    if (bank_clr) begin
      for (int i = 0; i < 32; i++) bank[i] <= '0;
    end else if (rf_write) begin
      bank[rf_addr] <= rf_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic v, input logic [4:0] a,
                         input logic [63:0] d);
    req_valid[i]        = v;
    req_addr[i*5 +: 5]  = a;
    req_data[i*64 +: 64] = d;
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_last = '{w: 1'b0, a: 5'd0, d: 64'd0, id: 3'd0};
    sb.delete();
  endtask

  // One clock cycle: predict the grant, check it, queue the expected write stage, then compare.
  task automatic step(input string tag);
    logic [2:0]  exp_rdy;
    exp_t        e;
    int unsigned w;
    bit          found;
    #1;
    exp_rdy = '0;
    found   = 1'b0;
    w       = 0;
    if (!stall && !reset) begin
      for (int unsigned k = 0; k < 3; k++) begin
        int unsigned j;
        j = (m_ptr + k) % 3;
        if (!found && req_valid[j]) begin
          found = 1'b1;
          w     = j;
        end
      end
    end
    if (found) exp_rdy[w] = 1'b1;
    check({tag, ".req_ready"}, 64'(req_ready), 64'(exp_rdy));
    check({tag, ".starve"}, 64'(starve), 64'd0);
    for (int i = 0; i < 3; i++) if (req_valid[i] && req_ready[i]) acc_obs[i]++;
    if (found) begin
      e.a    = req_addr[w*5 +: 5];
      e.d    = req_data[w*64 +: 64];
      e.id   = w[2:0];
      e.w    = (e.a != 5'd31);
      m_ptr  = (w + 1) % 3;
      m_last = e;
    end else begin
      e   = m_last;
      e.w = 1'b0;
    end
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s.scoreboard: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".rf_write"}, 64'(rf_write), 64'(e.w));
      check({tag, ".fwd_valid"}, 64'(fwd_valid), 64'(e.w));
      check({tag, ".rf_addr"}, 64'(rf_addr), 64'(e.a));
      check({tag, ".rf_data"}, rf_data, e.d);
      check({tag, ".grant_id"}, 64'(grant_id), 64'(e.id));
    end
  endtask

  initial begin
    reset     = 1'b1;
    stall     = 1'b0;
    bank_clr  = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("rst.rf_write", 64'(rf_write), 64'd0);
    check("rst.rf_addr", 64'(rf_addr), 64'd0);
    check("rst.rf_data", rf_data, 64'd0);
    check("rst.grant_id", 64'(grant_id), 64'd0);
    check("rst.starve", 64'(starve), 64'd0);
    reset    = 1'b0;
    bank_clr = 1'b0;

    // Single ALU write
    set_req(0, 1'b1, 5'd5, 64'hDEAD_BEEF);
    step("t1.grant");
    set_req(0, 1'b0, 5'd0, 64'd0);
    step("t1.idle");
    check("t1.bank5", bank[5], 64'hDEAD_BEEF);

    // Three continuous requesters
    for (int i = 0; i < 3; i++) acc_obs[i] = 0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(i + 1), 64'h100 + 64'(i));
    for (int c = 0; c < 6; c++) step("t2.rr");
    for (int i = 0; i < 3; i++) check("t2.accepted", 64'(acc_obs[i]), 64'd2);
    req_valid = '0;
    step("t2.idle");

    // Write to the zero register is swallowed
    set_req(1, 1'b1, 5'd31, 64'h7);
    step("t3.zr");
    set_req(1, 1'b0, 5'd0, 64'd0);
    set_req(0, 1'b1, 5'd4, 64'h44);
    step("t3.alu");
    set_req(0, 1'b0, 5'd0, 64'd0);
    step("t3.idle");
    check("t3.bank31", bank[31], 64'd0);
    check("t3.bank4", bank[4], 64'h44);

    // Stall with requests pending
    set_req(0, 1'b1, 5'd10, 64'hA0);
    set_req(1, 1'b1, 5'd11, 64'hA1);
    step("t4.pre");
    stall = 1'b1;
    for (int c = 0; c < 4; c++) step("t4.stall");
    stall = 1'b0;
    step("t4.resume0");
    step("t4.resume1");
    req_valid = '0;
    step("t4.idle");
    check("t4.bank10", bank[10], 64'hA0);
    check("t4.bank11", bank[11], 64'hA1);

    // Asynchronous reset while a write is staged
    set_req(0, 1'b1, 5'd9, 64'h99);
    step("t6.staged");
    #2;
    reset = 1'b1;
    #1;
    check("t6.rf_write_async", 64'(rf_write), 64'd0);
    check("t6.fwd_valid_async", 64'(fwd_valid), 64'd0);
    check("t6.rf_addr_async", 64'(rf_addr), 64'd0);
    check("t6.rf_data_async", rf_data, 64'd0);
    check("t6.req_ready_rst", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    check("t6.bank9", bank[9], 64'd0);

    // Two writers to the same destination, pointer back at 0
    set_req(0, 1'b1, 5'd30, 64'h11);
    set_req(2, 1'b1, 5'd30, 64'h22);
    #1;
    check("t5.first_grant", 64'(req_ready), 64'b001);
    step("t5.alu");
    set_req(0, 1'b0, 5'd0, 64'd0);
    step("t5.link");
    set_req(2, 1'b0, 5'd0, 64'd0);
    step("t5.idle");
    check("t5.bank30", bank[30], 64'h22);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish within 50000");
    $fatal(1);
  end

endmodule
